lane_stripes: RTL

LANE_STRIPES -- requirements
Module: lane_stripes

---
 rtl/lane_stripes_if.sv | 22 ++
 rtl/lane_stripes.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lane_stripes_if.sv
// Signal bundle between the game logic and the lane-stripe generator.
// The master drives the control inputs. The slave produces the stripe geometry.
interface lane_stripes_if;
   logic        frame_clk;
   logic        start;
   logic        menuLive;
   logic [10:0] difficulty;
   logic [10:0] StripeX [60];
   logic [10:0] StripeY [60];
   logic [10:0] Stripe_width;
   logic [10:0] Stripe_height;

   modport master (
      output frame_clk, start, menuLive, difficulty,
      input  StripeX, StripeY, Stripe_width, Stripe_height
   );

   modport slave (
      input  frame_clk, start, menuLive, difficulty,
      output StripeX, StripeY, Stripe_width, Stripe_height
   );
endinterface

// File: rtl/lane_stripes.sv
// Scrolling road-stripe generator. Sixty stripes are arranged as 6 columns x 10 rows.
// They scroll down by a speed that ramps toward a difficulty-derived target.
module lane_stripes #(
   parameter int COL_X0      = 80,
   parameter int COL_PITCH   = 96,
   parameter int ROW_PITCH   = 48,
   parameter int STRIPE_W    = 8,
   parameter int STRIPE_H    = 32,
   parameter int MAX_SPEED   = 12,
   parameter int RAMP_FRAMES = 8
) (
   input logic           Clk,
   input logic           Reset,
   lane_stripes_if.slave bus
);
   localparam int              N_STRIPES    = 60;
   localparam int              N_ROWS       = 10;
   localparam logic [11:0]     MAX_SPEED_12 = 12'(MAX_SPEED);
   localparam logic [7:0]      RAMP_LAST    = 8'(RAMP_FRAMES - 1);
   localparam logic [7:0]      ROW_PITCH_8  = 8'(ROW_PITCH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_frame_prev;
   logic        w_frame_evt;
   logic        w_advance;
   logic [5:0]  r_offset;
   logic [5:0]  w_offset_nxt;
   logic [7:0]  r_speed;
   logic [7:0]  w_speed_nxt;
   logic [7:0]  r_ramp;
   logic [7:0]  w_ramp_nxt;
   logic [7:0]  w_sum;
   logic [11:0] w_diff2;
   logic [11:0] w_target;
   logic [10:0] r_stripe_y [N_STRIPES];

   assign w_frame_evt = bus.frame_clk & ~r_frame_prev;
   // Doubling in 12 bits keeps difficulty=2047 from wrapping below the ceiling.
   assign w_diff2     = {bus.difficulty, 1'b0};
   assign w_target    = (w_diff2 > MAX_SPEED_12) ? MAX_SPEED_12 : w_diff2;
   assign w_sum       = {2'b00, r_offset} + r_speed;

   // State transitions. A frame advances only while RUN is kept for this edge.
   always_comb begin
      w_state_nxt = r_state;
      w_advance   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = RUN;
            else           w_state_nxt = IDLE;
         end
         RUN: begin
            if (!bus.start) begin
               w_state_nxt = IDLE;
            end else if (bus.menuLive) begin
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = RUN;
               w_advance   = w_frame_evt;
            end
         end
         HOLD: begin
            if (!bus.start)        w_state_nxt = IDLE;
            else if (!bus.menuLive) w_state_nxt = RUN;
            else                   w_state_nxt = HOLD;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Scroll offset and speed ramp. The offset moves by the speed held before this frame's ramp step.
   always_comb begin
      w_offset_nxt = r_offset;
      w_speed_nxt  = r_speed;
      w_ramp_nxt   = r_ramp;
      if (w_advance) begin
         if (w_sum >= ROW_PITCH_8) w_offset_nxt = 6'(w_sum - ROW_PITCH_8);
         else                      w_offset_nxt = 6'(w_sum);
         if (r_ramp == RAMP_LAST) begin
            w_ramp_nxt = 8'd0;
            if ({4'b0000, r_speed} < w_target)      w_speed_nxt = r_speed + 8'd1;
            else if ({4'b0000, r_speed} > w_target) w_speed_nxt = r_speed - 8'd1;
            else                                    w_speed_nxt = r_speed;
         end else begin
            w_ramp_nxt = r_ramp + 8'd1;
         end
      end else begin
         w_offset_nxt = r_offset;
      end
   end

   // Control state registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= IDLE;
         r_frame_prev <= 1'b0;
         r_offset     <= 6'd0;
         r_speed      <= 8'd0;
         r_ramp       <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_frame_prev <= bus.frame_clk;
         r_offset     <= w_offset_nxt;
         r_speed      <= w_speed_nxt;
         r_ramp       <= w_ramp_nxt;
      end
   end

   // Registered Y outputs. These lag the offset register by one clock.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N_STRIPES; i++)
            r_stripe_y[i] <= 11'((i % N_ROWS) * ROW_PITCH);
      end else begin
         for (int i = 0; i < N_STRIPES; i++)
            r_stripe_y[i] <= 11'((i % N_ROWS) * ROW_PITCH) + {5'b00000, r_offset};
      end
   end

   // Fixed geometry: the column X positions do not depend on state.
   always_comb begin
      for (int i = 0; i < N_STRIPES; i++) begin
         bus.StripeX[i] = 11'(COL_X0 + (i / N_ROWS) * COL_PITCH);
         bus.StripeY[i] = r_stripe_y[i];
      end
   end

   assign bus.Stripe_width  = 11'(STRIPE_W);
   assign bus.Stripe_height = 11'(STRIPE_H);

   lane_stripes_chk #(
      .ROW_PITCH (ROW_PITCH),
      .MAX_SPEED (MAX_SPEED)
   ) u_chk (
      .Clk      (Clk),
      .Reset    (Reset),
      .i_offset (r_offset),
      .i_speed  (r_speed),
      .i_state  (r_state)
   );
endmodule

// Invariants of the scroll datapath: offset stays inside one row pitch, speed stays under the ceiling, and the state is legal.
module lane_stripes_chk #(
   parameter int ROW_PITCH = 48,
   parameter int MAX_SPEED = 12
) (
   input logic       Clk,
   input logic       Reset,
   input logic [5:0] i_offset,
   input logic [7:0] i_speed,
   input logic [1:0] i_state
);
   a_offset_range: assert property (@(posedge Clk) disable iff (Reset)
      ({2'b00, i_offset} < 8'(ROW_PITCH)));
   a_speed_ceiling: assert property (@(posedge Clk) disable iff (Reset)
      (i_speed <= 8'(MAX_SPEED)));
   a_state_legal: assert property (@(posedge Clk) disable iff (Reset)
      (i_state != 2'd3));
endmodule
